// File: rtl/img_filter_ctrl.sv
// Frame controller: streams a source frame into an image filter, appends zero
// flush pixels, and writes the filter results into a result memory.
module img_filter_ctrl #(
   parameter int unsigned IMG_WIDTH  = 8,
   parameter int unsigned IMG_HEIGHT = 8,
   parameter int unsigned ADDR_W     = 6,
   parameter int unsigned FLUSH_LEN  = 9
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [1:0]        filter_sel,
   input  logic              hold,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [23:0]       rd_data,
   output logic [23:0]       flt_pixel,
   output logic              flt_valid,
   output logic [1:0]        flt_type,
   input  logic [23:0]       flt_out,
   input  logic              flt_out_valid,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [23:0]       wr_data,
   output logic              busy,
   output logic              done
);

   localparam int unsigned N  = IMG_WIDTH * IMG_HEIGHT;
   localparam int unsigned CW = ADDR_W + 1;
   localparam int unsigned FW = $clog2(FLUSH_LEN + 1);
   localparam logic [CW-1:0] NC   = CW'(N);
   localparam logic [CW-1:0] NM1  = CW'(N - 1);
   localparam logic [FW-1:0] FLM1 = FW'(FLUSH_LEN - 1);

   typedef enum logic [1:0] {StIdle, StFetch, StFlush, StDone} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
   logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
   logic [FW-1:0]     fl_cnt_q, fl_cnt_d;
   logic              rd_pend_q, rd_pend_d;
   logic              rd_en_q, rd_en_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [23:0]       flt_pixel_q, flt_pixel_d;
   logic              flt_valid_q, flt_valid_d;
   logic [1:0]        flt_type_q, flt_type_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [23:0]       wr_data_q, wr_data_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
         fl_cnt_q    <= '0;
         rd_pend_q   <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         flt_pixel_q <= '0;
         flt_valid_q <= 1'b0;
         flt_type_q  <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
         fl_cnt_q    <= fl_cnt_d;
         rd_pend_q   <= rd_pend_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         flt_pixel_q <= flt_pixel_d;
         flt_valid_q <= flt_valid_d;
         flt_type_q  <= flt_type_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rd_cnt_d    = rd_cnt_q;
      wr_cnt_d    = wr_cnt_q;
      fl_cnt_d    = fl_cnt_q;
      rd_en_d     = 1'b0;
      rd_addr_d   = rd_addr_q;
      flt_pixel_d = flt_pixel_q;
      flt_valid_d = 1'b0;
      flt_type_d  = flt_type_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      done_d      = 1'b0;
      // Read data arrives the cycle after the strobe; forward it regardless of hold
      rd_pend_d   = rd_en_q;
      if (rd_pend_q) begin
         flt_pixel_d = rd_data;
         flt_valid_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StFetch;
               flt_type_d = filter_sel;
               rd_cnt_d   = '0;
               wr_cnt_d   = '0;
               fl_cnt_d   = '0;
            end
         end
         StFetch: begin
            if (!hold) begin
               rd_en_d   = 1'b1;
               rd_addr_d = rd_cnt_q[ADDR_W-1:0];
               rd_cnt_d  = rd_cnt_q + 1'b1;
               if (rd_cnt_q == NM1) state_d = StFlush;
            end
         end
         StFlush: begin
            // Zeros wait until the final source pixel has been forwarded
            if (!hold && !rd_en_q && !rd_pend_q) begin
               flt_pixel_d = '0;
               flt_valid_d = 1'b1;
               fl_cnt_d    = fl_cnt_q + 1'b1;
               if (fl_cnt_q == FLM1) state_d = StDone;
            end
         end
         StDone: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (busy_q && flt_out_valid && (wr_cnt_q < NC)) begin
         wr_en_d   = 1'b1;
         wr_addr_d = wr_cnt_q[ADDR_W-1:0];
         wr_data_d = flt_out;
         wr_cnt_d  = wr_cnt_q + 1'b1;
      end

      busy_d = (state_d == StFetch) || (state_d == StFlush);
   end

   assign rd_en     = rd_en_q;
   assign rd_addr   = rd_addr_q;
   assign flt_pixel = flt_pixel_q;
   assign flt_valid = flt_valid_q;
   assign flt_type  = flt_type_q;
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_img_filter_ctrl.sv
// Self-checking bench for img_filter_ctrl on a 4x4 frame with random pixels,
// random hold placement and a random filter result stream.
module tb_img_filter_ctrl;

   localparam int W = 4, H = 4, AW = 4, FL = 9, N = W * H;

   logic          clk = 1'b0, reset_n = 1'b1, start = 1'b0, hold = 1'b0;
   logic [1:0]    filter_sel = 2'b00;
   logic          rd_en, flt_valid, wr_en, busy, done;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [23:0]   rd_data = '0, flt_pixel, wr_data, flt_out = '0;
   logic [1:0]    flt_type;
   logic          flt_out_valid = 1'b0;

   img_filter_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .ADDR_W(AW), .FLUSH_LEN(FL)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .filter_sel(filter_sel), .hold(hold),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .flt_pixel(flt_pixel),
      .flt_valid(flt_valid), .flt_type(flt_type), .flt_out(flt_out),
      .flt_out_valid(flt_out_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic [23:0] src [N];
   always @(posedge clk) if (rd_en) rd_data <= src[rd_addr];

   int n_cmp = 0, n_bad = 0;
   logic [23:0] pix_q[$], exp_w[$], wr_d[$];
   int pix_cyc[$], rd_cyc[$], rd_adr[$], done_cyc[$], wr_a[$], wr_c[$], exp_wc[$];
   int type_bad;
   bit tmo;

   function automatic logic [23:0] exp_pix(int i);
      return (i < N) ? src[i] : 24'd0;
   endfunction

   task automatic load_src();
      for (int i = 0; i < N; i++) src[i] = 24'($urandom);
   endtask

   // Runs one frame, driving hold/mid-frame start/filter results and recording outputs.
   task automatic run_frame(input logic [1:0] sel, input int trig, input int hlen,
                            input int mid_at, input int ov_len);
      int cyc, hl, ovl;
      bit trig_done, ov_on;
      pix_q.delete(); pix_cyc.delete(); rd_cyc.delete(); rd_adr.delete();
      done_cyc.delete(); wr_a.delete(); wr_d.delete(); wr_c.delete();
      exp_w.delete(); exp_wc.delete();
      type_bad = 0; trig_done = 0; ov_on = 0; hl = 0; ovl = 0;
      @(negedge clk); filter_sel = sel; start = 1'b1;
      @(negedge clk); start = 1'b0; filter_sel = 2'($urandom);
      cyc = 0;
      while (cyc < 200 && !(done_cyc.size() > 0 && cyc > done_cyc[0] + 3)) begin
         if (flt_valid) begin pix_q.push_back(flt_pixel); pix_cyc.push_back(cyc); end
         if (rd_en) begin rd_cyc.push_back(cyc); rd_adr.push_back(int'(rd_addr)); end
         if (wr_en) begin wr_a.push_back(int'(wr_addr)); wr_d.push_back(wr_data);
            wr_c.push_back(cyc); end
         if (done) done_cyc.push_back(cyc);
         if (flt_type !== sel) type_bad++;
         if (rd_en && int'(rd_addr) == trig && !trig_done) begin trig_done = 1; hl = hlen; end
         hold = (hl > 0);
         if (hl > 0) hl--;
         start = (mid_at >= 0 && rd_en && int'(rd_addr) == mid_at);
         if (start) filter_sel = 2'b00;
         if (busy && !ov_on) begin ov_on = 1; ovl = ov_len; end
         flt_out_valid = (ovl > 0);
         if (ovl > 0) ovl--;
         flt_out = 24'($urandom);
         if (flt_out_valid && busy && exp_w.size() < N) begin
            exp_w.push_back(flt_out); exp_wc.push_back(cyc + 1);
         end
         @(negedge clk); cyc++;
      end
      tmo = (done_cyc.size() == 0);
      hold = 1'b0; start = 1'b0; flt_out_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [84:0] outs;
      reset_n = 1'b0; #3;
      outs = {rd_en, flt_valid, wr_en, busy, done, rd_addr, wr_addr, flt_pixel, wr_data, flt_type};
      n_cmp++; if (outs !== '0) begin n_bad++;
         $display("FAIL reset_outputs: got %h want 0", outs); end
      repeat (2) @(negedge clk);
      n_cmp++; if ({rd_en, flt_valid, busy, done} !== 4'b0) begin n_bad++;
         $display("FAIL reset_held: got %b want 0000", {rd_en, flt_valid, busy, done}); end
      reset_n = 1'b1;
   endtask

   task automatic test_basic();
      int e;
      load_src();
      run_frame(2'b01, -1, 0, -1, 0);
      n_cmp++; if (tmo) begin n_bad++; $display("FAIL basic_timeout: no done seen"); end
      e = 0;
      for (int i = 0; i < rd_adr.size(); i++) if (rd_adr[i] != i || rd_cyc[i] != rd_cyc[0] + i) e++;
      n_cmp++; if (rd_adr.size() != N || e != 0) begin n_bad++;
         $display("FAIL basic_rd_seq: got %0d reads %0d bad want %0d reads 0 bad", rd_adr.size(), e, N); end
      e = 0;
      for (int i = 0; i < pix_q.size(); i++) if (pix_q[i] !== exp_pix(i)) e++;
      n_cmp++; if (pix_q.size() != N + FL || e != 0) begin n_bad++;
         $display("FAIL basic_stream: got %0d pixels %0d bad want %0d pixels 0 bad", pix_q.size(), e, N + FL); end
      n_cmp++; if (type_bad != 0) begin n_bad++;
         $display("FAIL basic_type: got %0d bad cycles want 0", type_bad); end
      n_cmp++; if (done_cyc.size() != 1 || pix_cyc.size() == 0 ||
                   done_cyc[0] != pix_cyc[pix_cyc.size()-1] + 1) begin n_bad++;
         $display("FAIL basic_done: got %0d pulses want 1 one cycle after last pixel", done_cyc.size()); end
   endtask

   task automatic test_hold();
      int e;
      load_src();
      run_frame(2'($urandom), 4, 3, -1, 0);
      e = 0;
      for (int i = 1; i < rd_adr.size(); i++)
         if (rd_adr[i] != i || rd_cyc[i] - rd_cyc[i-1] != ((i == 5) ? 4 : 1)) e++;
      n_cmp++; if (rd_adr.size() != N || e != 0) begin n_bad++;
         $display("FAIL hold_rd_gap: got %0d reads %0d bad want %0d reads 0 bad", rd_adr.size(), e, N); end
      e = 0;
      for (int i = 0; i < pix_q.size(); i++) if (pix_q[i] !== exp_pix(i)) e++;
      n_cmp++; if (pix_q.size() != N + FL || e != 0) begin n_bad++;
         $display("FAIL hold_stream: got %0d pixels %0d bad want %0d pixels 0 bad", pix_q.size(), e, N + FL); end
   endtask

   task automatic test_midstart();
      int e;
      load_src();
      run_frame(2'b10, -1, 0, 6, 0);
      n_cmp++; if (type_bad != 0) begin n_bad++;
         $display("FAIL midstart_type: got %0d bad cycles want 0", type_bad); end
      e = 0;
      for (int i = 0; i < rd_adr.size(); i++) if (rd_adr[i] != i || rd_cyc[i] != rd_cyc[0] + i) e++;
      n_cmp++; if (rd_adr.size() != N || e != 0) begin n_bad++;
         $display("FAIL midstart_rd_seq: got %0d reads %0d bad want %0d reads 0 bad", rd_adr.size(), e, N); end
      n_cmp++; if (done_cyc.size() != 1) begin n_bad++;
         $display("FAIL midstart_done: got %0d pulses want 1", done_cyc.size()); end
   endtask

   task automatic test_write();
      int e;
      load_src();
      run_frame(2'b11, -1, 0, -1, 20);
      n_cmp++; if (wr_a.size() != N || exp_w.size() != N) begin n_bad++;
         $display("FAIL write_count: got %0d writes want %0d", wr_a.size(), N); end
      e = 0;
      for (int i = 0; i < wr_a.size() && i < exp_w.size(); i++)
         if (wr_a[i] != i || wr_d[i] !== exp_w[i] || wr_c[i] != exp_wc[i]) e++;
      n_cmp++; if (e != 0) begin n_bad++;
         $display("FAIL write_content: got %0d bad writes want 0", e); end
   endtask

   task automatic test_tail_hold();
      int e;
      load_src();
      run_frame(2'b01, N - 1, 2, -1, 0);
      e = 0;
      for (int i = 0; i < pix_q.size(); i++) if (pix_q[i] !== exp_pix(i)) e++;
      n_cmp++; if (pix_q.size() != N + FL || e != 0) begin n_bad++;
         $display("FAIL tail_stream: got %0d pixels %0d bad want %0d pixels 0 bad", pix_q.size(), e, N + FL); end
      n_cmp++; if (done_cyc.size() != 1 || pix_cyc.size() == 0 ||
                   done_cyc[0] != pix_cyc[pix_cyc.size()-1] + 1) begin n_bad++;
         $display("FAIL tail_done: got %0d pulses want 1 one cycle after last pixel", done_cyc.size()); end
   endtask

   task automatic test_reset_abort();
      int k, e;
      logic [84:0] outs;
      load_src();
      @(negedge clk); filter_sel = 2'b10; start = 1'b1;
      @(negedge clk); start = 1'b0;
      k = 0;
      while (!(rd_en && rd_addr == 4'd7) && k < 100) begin @(negedge clk); k++; end
      n_cmp++; if (k >= 100) begin n_bad++; $display("FAIL abort_reach: rd_addr 7 not seen"); end
      #2 reset_n = 1'b0; #1;
      outs = {rd_en, flt_valid, wr_en, busy, done, rd_addr, wr_addr, flt_pixel, wr_data, flt_type};
      n_cmp++; if (outs !== '0) begin n_bad++;
         $display("FAIL abort_outputs: got %h want 0", outs); end
      @(negedge clk); reset_n = 1'b1;
      e = 0;
      repeat (20) begin @(negedge clk); if ({done, busy, rd_en, flt_valid} !== 4'b0) e++; end
      n_cmp++; if (e != 0) begin n_bad++;
         $display("FAIL abort_quiet: got %0d active cycles want 0", e); end
      run_frame(2'($urandom), -1, 0, -1, 0);
      n_cmp++; if (rd_adr.size() != N || rd_adr[0] != 0 || done_cyc.size() != 1) begin n_bad++;
         $display("FAIL abort_restart: got %0d reads %0d pulses want %0d reads 1 pulse",
                  rd_adr.size(), done_cyc.size(), N); end
   endtask

   task automatic test_back_to_back();
      int e;
      for (int f = 0; f < 3; f++) begin
         load_src();
         run_frame(2'($urandom), $urandom_range(N - 1), $urandom_range(3), -1, $urandom_range(30));
         e = 0;
         for (int i = 0; i < pix_q.size(); i++) if (pix_q[i] !== exp_pix(i)) e++;
         for (int i = 0; i < wr_a.size() && i < exp_w.size(); i++)
            if (wr_a[i] != i || wr_d[i] !== exp_w[i] || wr_c[i] != exp_wc[i]) e++;
         n_cmp++; if (pix_q.size() != N + FL || wr_a.size() != exp_w.size() || e != 0 ||
                      type_bad != 0 || done_cyc.size() != 1) begin n_bad++;
            $display("FAIL b2b_frame%0d: got %0d pixels %0d writes %0d bad want %0d pixels %0d writes 0 bad",
                     f, pix_q.size(), wr_a.size(), e, N + FL, exp_w.size()); end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_basic();
      test_hold();
      test_midstart();
      test_write();
      test_tail_hold();
      test_reset_abort();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
